rms_norm_lanes: RTL and testbench

- Parametrised successor to the single-lane RMS normaliser.
- Normalises a D-element signed fixed-point vector by its root-mean-square and optionally applies a per-element gain (gamma).
- Processes LANES elements per cycle, adds an epsilon term, and computes sqrt and reciprocal with exact sequential integer arithmetic (no LUTs).
- Uses valid/ready handshakes with output backpressure. Sits between the matmul unit output and the next layer's input buffer.

---
 rtl/rms_norm_lanes.sv | 183 ++++++++++++++++++
 tb/tb_rms_norm_lanes.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rms_norm_lanes.sv
// RMS normaliser: squares LANES elements per cycle, then exact sequential sqrt and
// reciprocal, then scales (and optionally gains) LANES elements per cycle.
module rms_norm_lanes #(
   parameter int D        = 64,
   parameter int LANES    = 4,
   parameter int WIDTH    = 16,
   parameter int FRAC     = 8,
   parameter int EPS      = 0,
   parameter int USE_GAIN = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [D*WIDTH-1:0]   a_i,
   input  logic [D*WIDTH-1:0]   g_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [D*WIDTH-1:0]   result_o
);
   localparam int GROUPS  = D / LANES;
   localparam int LOG_D   = $clog2(D);
   localparam int ACC_W   = 2*WIDTH + LOG_D;
   localparam int MS_W    = 2*WIDTH;
   localparam int INV_W   = 2*FRAC + 1;
   localparam int REM_W   = WIDTH + 3;
   localparam int PW      = (WIDTH + INV_W + 1 > 2*WIDTH) ? WIDTH + INV_W + 1 : 2*WIDTH;
   localparam int MAX_CNT = (GROUPS > WIDTH) ? ((GROUPS > INV_W) ? GROUPS : INV_W)
                                             : ((WIDTH > INV_W) ? WIDTH : INV_W);
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   typedef enum logic [2:0] {IDLE, ACCUM, SQRT, RECIP, SCALE, OUT} state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [D*WIDTH-1:0]   x_reg, g_reg, result_reg;
   logic [ACC_W-1:0]     acc_reg, acc_next, group_sum;
   logic [MS_W-1:0]      ms_reg, ms_sat;
   logic [ACC_W:0]       ms_full;
   logic [REM_W-1:0]     rem_reg, rem_next, sq_cand, sq_trial;
   logic [WIDTH-1:0]     root_reg, root_next;
   logic [WIDTH:0]       drem_reg, drem_next, dv_cand;
   logic [INV_W-1:0]     inv_reg;
   logic                 q_bit;
   logic [ACC_W-1:0]     lane_sq [LANES];
   logic [WIDTH-1:0]     lane_y  [LANES];

   function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
      logic [PW-WIDTH:0] top;
      top = v[PW-1:WIDTH-1];
      if (&top || ~|top) return v[WIDTH-1:0];
      return v[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   // Per-lane square (accumulate phase) and scale/gain (output phase) share element select.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [WIDTH-1:0]   xl, gl, y1;
      logic signed [2*WIDTH-1:0] xs, sq;
      logic signed [PW-1:0]      xe, ye, ge, p1, p2;
      assign xl = x_reg[(int'(cnt_reg)*LANES + gi)*WIDTH +: WIDTH];
      assign gl = g_reg[(int'(cnt_reg)*LANES + gi)*WIDTH +: WIDTH];
      assign xs = {{WIDTH{xl[WIDTH-1]}}, xl};
      assign sq = xs * xs;
      assign lane_sq[gi] = ACC_W'(unsigned'(sq));
      assign xe = {{(PW-WIDTH){xl[WIDTH-1]}}, xl};
      assign p1 = xe * $signed({{(PW-INV_W){1'b0}}, inv_reg});
      assign y1 = sat(p1 >>> FRAC);
      assign ye = {{(PW-WIDTH){y1[WIDTH-1]}}, y1};
      assign ge = {{(PW-WIDTH){gl[WIDTH-1]}}, gl};
      assign p2 = ye * ge;
      assign lane_y[gi] = (USE_GAIN != 0) ? sat(p2 >>> FRAC) : y1;
   end

   always_comb begin
      group_sum = '0;
      for (int l = 0; l < LANES; l++) group_sum = group_sum + lane_sq[l];
      acc_next = acc_reg + group_sum;
      ms_full  = {1'b0, acc_next >> LOG_D} + (ACC_W+1)'(EPS);
      ms_sat   = (|ms_full[ACC_W:MS_W]) ? {MS_W{1'b1}} : ms_full[MS_W-1:0];
   end

   // One result bit per cycle: restoring bit-pair square root.
   always_comb begin
      sq_cand  = {rem_reg[REM_W-3:0], ms_reg[MS_W-1 -: 2]};
      sq_trial = REM_W'({root_reg, 2'b01});
      if (sq_cand >= sq_trial) begin
         rem_next  = sq_cand - sq_trial;
         root_next = {root_reg[WIDTH-2:0], 1'b1};
      end else begin
         rem_next  = sq_cand;
         root_next = {root_reg[WIDTH-2:0], 1'b0};
      end
   end

   // Dividend 2^(2*FRAC) has only its MSB set, fed in on the first step; rms==0 yields all ones.
   always_comb begin
      dv_cand = {drem_reg[WIDTH-1:0], (cnt_reg == '0)};
      if (dv_cand >= {1'b0, root_reg}) begin
         drem_next = dv_cand - {1'b0, root_reg};
         q_bit     = 1'b1;
      end else begin
         drem_next = dv_cand;
         q_bit     = 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid_i)                      state_next = ACCUM;
         ACCUM:   if (cnt_reg == CNT_W'(GROUPS-1))     state_next = SQRT;
         SQRT:    if (cnt_reg == CNT_W'(WIDTH-1))      state_next = RECIP;
         RECIP:   if (cnt_reg == CNT_W'(INV_W-1))      state_next = SCALE;
         SCALE:   if (cnt_reg == CNT_W'(GROUPS-1))     state_next = OUT;
         OUT:     if (out_ready_i)                     state_next = IDLE;
         default:                                      state_next = IDLE;
      endcase
      if (state_next != state_reg || state_reg == IDLE || state_reg == OUT) cnt_next = '0;
      else                                                                  cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_reg      <= '0;
         g_reg      <= '0;
         acc_reg    <= '0;
         ms_reg     <= '0;
         rem_reg    <= '0;
         root_reg   <= '0;
         drem_reg   <= '0;
         inv_reg    <= '0;
         result_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid_i) begin
               x_reg   <= a_i;
               g_reg   <= g_i;
               acc_reg <= '0;
            end
            ACCUM: begin
               acc_reg <= acc_next;
               if (cnt_reg == CNT_W'(GROUPS-1)) begin
                  ms_reg   <= ms_sat;
                  rem_reg  <= '0;
                  root_reg <= '0;
               end
            end
            SQRT: begin
               ms_reg   <= ms_reg << 2;
               rem_reg  <= rem_next;
               root_reg <= root_next;
               if (cnt_reg == CNT_W'(WIDTH-1)) begin
                  drem_reg <= '0;
                  inv_reg  <= '0;
               end
            end
            RECIP: begin
               drem_reg <= drem_next;
               inv_reg  <= {inv_reg[INV_W-2:0], q_bit};
            end
            SCALE: begin
               for (int l = 0; l < LANES; l++)
                  result_reg[(int'(cnt_reg)*LANES + l)*WIDTH +: WIDTH] <= lane_y[l];
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (state_reg == IDLE);
   assign out_valid_o = (state_reg == OUT);
   assign result_o    = result_reg;
endmodule

// File: tb/tb_rms_norm_lanes.sv
// Directed bench for rms_norm_lanes: default, EPS=65536 and USE_GAIN=0 instances share stimulus.
module tb_rms_norm_lanes;
   localparam int D = 64;
   localparam int W = 16;
   localparam int L = 65;
   localparam int N = 6;

   logic clk = 1'b0;
   logic rst, in_valid, out_ready;
   logic [D*W-1:0] a, g, res_def, res_eps, res_ng;
   logic in_ready, out_valid, rdy_eps, vld_eps, rdy_ng, vld_ng;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rms_norm_lanes dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .g_i(g), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(res_def));
   rms_norm_lanes #(.EPS(65536)) dut_eps (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_eps),
      .a_i(a), .g_i(g), .out_valid_o(vld_eps), .out_ready_i(out_ready), .result_o(res_eps));
   rms_norm_lanes #(.USE_GAIN(0)) dut_ng (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_ng),
      .a_i(a), .g_i(g), .out_valid_o(vld_ng), .out_ready_i(out_ready), .result_o(res_ng));

   typedef struct {
      logic [W-1:0] xe, xo, ge;
      bit           spike;
      logic [W-1:0] de, dodd, ee, eodd, ne, nodd;
   } vec_t;
   vec_t tv [N];

   // spike=1: element 0 takes the "e" value, the rest the "o" value; otherwise even/odd.
   function automatic logic [D*W-1:0] build(logic [W-1:0] e, logic [W-1:0] o, bit spike);
      logic [D*W-1:0] v;
      for (int k = 0; k < D; k++)
         v[k*W +: W] = spike ? ((k == 0) ? e : o) : ((k % 2 == 0) ? e : o);
      return v;
   endfunction

   task automatic chk_int(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(string name, logic [D*W-1:0] act, logic [D*W-1:0] exp);
      int bad = -1;
      tests++;
      for (int k = 0; k < D; k++)
         if (bad < 0 && act[k*W +: W] !== exp[k*W +: W]) bad = k;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s elem %0d got %0d want %0d", name, bad,
                  $signed(act[bad*W +: W]), $signed(exp[bad*W +: W]));
      end
   endtask

   task automatic send(input vec_t v, input bit ready_early);
      @(negedge clk);
      a = build(v.xe, v.xo, v.spike);
      g = build(v.ge, v.ge, 1'b0);
      in_valid = 1'b1;
      out_ready = ready_early;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_results(input vec_t v, input string tag);
      chk_vec({tag, "_def"}, res_def, build(v.de, v.dodd, v.spike));
      chk_vec({tag, "_eps"}, res_eps, build(v.ee, v.eodd, v.spike));
      chk_vec({tag, "_nogain"}, res_ng, build(v.ne, v.nodd, v.spike));
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_int({tag, "_valid_drop"}, int'(out_valid), 0);
      chk_int({tag, "_ready_back"}, int'(in_ready), 1);
   endtask

   initial begin
      int lat;
      bit stable;
      logic [D*W-1:0] held;
      string tag;

      tv[0] = '{xe:16'd256, xo:16'd256, ge:16'd256, spike:0,
                de:16'd256, dodd:16'd256, ee:16'd181, eodd:16'd181, ne:16'd256, nodd:16'd256};
      tv[1] = '{xe:16'd512, xo:-16'sd512, ge:16'd256, spike:0,
                de:16'd256, dodd:-16'sd256, ee:16'd228, eodd:-16'sd228, ne:16'd256, nodd:-16'sd256};
      tv[2] = '{xe:16'd0, xo:16'd0, ge:16'd256, spike:0,
                de:16'd0, dodd:16'd0, ee:16'd0, eodd:16'd0, ne:16'd0, nodd:16'd0};
      tv[3] = '{xe:16'd32767, xo:16'd0, ge:16'd32767, spike:1,
                de:16'd32767, dodd:16'd0, ee:16'd32767, eodd:16'd0, ne:16'd2047, nodd:16'd0};
      tv[4] = '{xe:-16'sd1, xo:-16'sd1, ge:-16'sd128, spike:0,
                de:16'd128, dodd:16'd128, ee:16'd0, eodd:16'd0, ne:-16'sd256, nodd:-16'sd256};
      tv[5] = '{xe:-16'sd3, xo:-16'sd3, ge:16'd256, spike:0,
                de:-16'sd256, dodd:-16'sd256, ee:-16'sd3, eodd:-16'sd3, ne:-16'sd256, nodd:-16'sd256};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; g = '0;
      @(posedge clk); #1;
      chk_int("reset_in_ready", int'(in_ready), 1);
      chk_int("reset_out_valid", int'(out_valid), 0);
      chk_vec("reset_result", res_def, '0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < N; i++) begin
         tag = $sformatf("vec%0d", i);
         send(tv[i], i == 1);
         chk_int({tag, "_accepted"}, int'(in_ready), 0);
         wait_out(lat);
         chk_int({tag, "_latency"}, lat, L);
         check_results(tv[i], tag);
         $display("[TB] %s latency %0d elem0 def=%0d eps=%0d nogain=%0d", tag, lat,
                  $signed(res_def[W-1:0]), $signed(res_eps[W-1:0]), $signed(res_ng[W-1:0]));
         if (i == 1) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk_int({tag, "_early_ready_valid_drop"}, int'(out_valid), 0);
            chk_int({tag, "_early_ready_back"}, int'(in_ready), 1);
         end else begin
            handshake(tag);
         end
      end

      send(tv[0], 1'b0);
      wait_out(lat);
      chk_int("bp_latency", lat, L);
      held = res_def;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         a = {32{$urandom}};
         @(posedge clk); #1;
         if (!out_valid || in_ready || res_def !== held) stable = 1'b0;
      end
      chk_int("bp_hold_stable", int'(stable), 1);
      chk_vec("bp_result", res_def, build(16'd256, 16'd256, 1'b0));
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_int("bp_valid_drop", int'(out_valid), 0);
      chk_int("bp_no_same_cycle_accept", int'(in_ready), 1);
      in_valid = 1'b0;
      $display("[TB] backpressure sequence done");

      send(tv[1], 1'b0);
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_int("rst_out_valid", int'(out_valid), 0);
      chk_vec("rst_result_cleared", res_def, '0);
      chk_int("rst_in_ready", int'(in_ready), 1);
      @(negedge clk); rst = 1'b0;
      send(tv[1], 1'b0);
      wait_out(lat);
      chk_int("post_rst_latency", lat, L);
      check_results(tv[1], "post_rst");
      handshake("post_rst");
      $display("[TB] reset-during-sqrt sequence done latency %0d", lat);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
